// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and widths for the pipeline stage registers
package pipe_pkg;

    // Payload widths of the inter-stage registers
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 128;
    localparam int EX_MEM_W = 96;
    localparam int MEM_WB_W = 72;

    // Instruction NOP encoding used when a stage holds no valid beat
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Occupancy state; the encoding equals the number of held entries
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

    // Number of entries a flush discards: whatever is held minus what leaves this cycle
    function automatic logic [1:0] flush_drops(input logic [1:0] occ, input logic out_fire);
        return occ - {1'b0, out_fire};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready/data handshake bundle between pipeline stages
interface pipe_stage_skid_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    // Side that presents beats
    modport master (
        output valid,
        output data,
        input  ready
    );

    // Side that accepts beats
    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - elastic pipeline stage register with optional skid entry and flush
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int              DATA_W   = IF_ID_W,
    parameter bit              SKID     = 1'b1,
    parameter logic [DATA_W-1:0] NOP_DATA = '0,
    parameter int              CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_stage_skid_if.slave   in_bus,
    pipe_stage_skid_if.master  out_bus,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   flush_drop_cnt
);

    occ_state_e        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_val;
    logic              in_ready;
    logic              in_fire;
    logic              out_fire;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    cnt_sum;
    logic [1:0]        drop_n;

    assign occupancy         = state_q;
    assign out_bus.valid     = (state_q != OCC_EMPTY);
    assign out_bus.data      = out_bus.valid ? main_q : NOP_DATA;
    assign in_bus.ready      = in_ready;
    assign flush_drop_cnt    = cnt_q;

    assign in_fire  = in_bus.valid & in_ready & ~flush;
    assign out_fire = out_bus.valid & out_bus.ready;

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] skid_q, skid_d;

            // Registered ready: the only thing that blocks input is a full skid entry
            assign in_ready = ~reset & (state_q != OCC_TWO);
            assign skid_val = skid_q;

            // Park the incoming beat in the skid entry when main is occupied and stalled
            always_comb begin
                skid_d = skid_q;
                if ((state_q == OCC_ONE) && in_fire && !out_fire) begin
                    skid_d = in_bus.data;
                end
            end

            // Skid storage; its contents are meaningless while state is below TWO
            always_ff @(posedge clk) begin
                if (reset) begin
                    skid_q <= NOP_DATA;
                end else begin
                    skid_q <= skid_d;
                end
            end
        end else begin : g_no_skid
            // Single entry: may accept only if empty or the held beat leaves this cycle
            assign in_ready = ~reset & ((state_q == OCC_EMPTY) | out_bus.ready);
            assign skid_val = NOP_DATA;
        end
    endgenerate

    // Next occupancy and head entry; flush overrides everything but reset
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        unique case (state_q)
            OCC_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_bus.data;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_bus.data;
                end else if (in_fire && SKID) begin
                    state_d = OCC_TWO;
                end else if (out_fire) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (out_fire) begin
                    main_d  = skid_val;
                    state_d = OCC_ONE;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = OCC_EMPTY;
        end
    end

    // Head entry and occupancy state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            main_q  <= NOP_DATA;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    // Saturating count of entries thrown away by flush; a beat leaving in the flush cycle is delivered
    always_comb begin
        drop_n  = flush_drops(state_q, out_fire);
        cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(drop_n);
        cnt_d   = cnt_q;
        if (flush) begin
            cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = IF_ID_W;

    logic clk = 1'b0;
    logic reset;
    logic flush_a;
    logic flush_b;
    logic [1:0]  occ_a;
    logic [1:0]  occ_b;
    logic [1:0]  cnt_a;
    logic [15:0] cnt_b;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] nop_val;

    always #5 clk = ~clk;

    pipe_stage_skid_if #(.DATA_W(DW)) a_in ();
    pipe_stage_skid_if #(.DATA_W(DW)) a_out ();
    pipe_stage_skid_if #(.DATA_W(DW)) b_in ();
    pipe_stage_skid_if #(.DATA_W(DW)) b_out ();

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b1), .CNT_W(2)) u_skid (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush_a),
        .in_bus         (a_in),
        .out_bus        (a_out),
        .occupancy      (occ_a),
        .flush_drop_cnt (cnt_a)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b0), .CNT_W(16)) u_noskid (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush_b),
        .in_bus         (b_in),
        .out_bus        (b_out),
        .occupancy      (occ_b),
        .flush_drop_cnt (cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush_a = 1'b0;
        flush_b = 1'b0;
        a_in.valid = 1'b1;
        a_in.data = 64'h00000013_00000004;
        a_out.ready = 1'b1;
        b_in.valid = 1'b0;
        b_in.data = '0;
        b_out.ready = 1'b1;
        nop_val = {NOP_INSTR, 32'h0};
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (a_in.ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready_a cyc=%0d got=%b exp=0", c, a_in.ready);
            end
            checks++;
            if (b_in.ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready_b cyc=%0d got=%b exp=0", c, b_in.ready);
            end
        end
        checks++;
        if (a_out.valid !== 1'b0 || a_out.data !== nop_val || occ_a !== 2'd0 || cnt_a !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h occ=%0d cnt=%0d exp v=0 d=%h occ=0 cnt=0",
                     a_out.valid, a_out.data, occ_a, cnt_a, nop_val);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (a_in.ready !== 1'b1 || a_out.data !== 64'h0 || a_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle got rdy=%b v=%b d=%h exp rdy=1 v=0 d=0",
                     a_in.ready, a_out.valid, a_out.data);
        end
        tick();
        checks++;
        if (a_out.valid !== 1'b1 || a_out.data !== 64'h00000013_00000004 || occ_a !== 2'd1) begin
            errors++;
            $display("FAIL latency got v=%b d=%h occ=%0d exp v=1 d=0000001300000004 occ=1",
                     a_out.valid, a_out.data, occ_a);
        end
        a_in.valid = 1'b0;
        tick();
        checks++;
        if (a_out.valid !== 1'b0 || a_out.data !== 64'h0 || occ_a !== 2'd0) begin
            errors++;
            $display("FAIL drain got v=%b d=%h occ=%0d exp v=0 d=0 occ=0",
                     a_out.valid, a_out.data, occ_a);
        end
    endtask

    task automatic test_backpressure();
        logic          exp_rdy;
        logic [DW-1:0] exp_d;
        a_out.ready = 1'b0;
        a_in.valid = 1'b1;
        a_in.data = 64'd1;
        #1;
        checks++;
        if (a_in.ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_empty got=%b exp=1", a_in.ready);
        end
        tick();
        a_in.data = 64'd2;
        tick();
        a_in.data = 64'd3;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (occ_a !== 2'd2 || a_in.ready !== 1'b0 || a_out.data !== 64'd1) begin
                errors++;
                $display("FAIL bp_full cyc=%0d got occ=%0d rdy=%b d=%h exp occ=2 rdy=0 d=1",
                         c, occ_a, a_in.ready, a_out.data);
            end
            if (c == 0) tick();
        end
        tick();
        // Drain: beat 3 is held at the input until a slot opens, then 4 follows
        for (int k = 0; k < 4; k++) begin
            a_out.ready = 1'b1;
            a_in.valid = (k < 3);
            a_in.data = (k == 2) ? 64'd4 : 64'd3;
            exp_rdy = (k != 0);
            exp_d = 64'(k + 1);
            #1;
            checks++;
            if (a_out.valid !== 1'b1 || a_out.data !== exp_d || a_in.ready !== exp_rdy) begin
                errors++;
                $display("FAIL bp_order k=%0d got v=%b d=%h rdy=%b exp v=1 d=%h rdy=%b",
                         k, a_out.valid, a_out.data, a_in.ready, exp_d, exp_rdy);
            end
            tick();
        end
        a_in.valid = 1'b0;
        #1;
        checks++;
        if (occ_a !== 2'd0 || a_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty got occ=%0d v=%b exp occ=0 v=0", occ_a, a_out.valid);
        end
    endtask

    task automatic test_flush_out_fire();
        a_out.ready = 1'b0;
        a_in.valid = 1'b1;
        a_in.data = 64'h55;
        tick();
        a_in.valid = 1'b0;
        a_out.ready = 1'b1;
        flush_a = 1'b1;
        #1;
        checks++;
        if (a_out.valid !== 1'b1 || a_out.data !== 64'h55) begin
            errors++;
            $display("FAIL flush_fire_deliver got v=%b d=%h exp v=1 d=55", a_out.valid, a_out.data);
        end
        tick();
        flush_a = 1'b0;
        #1;
        checks++;
        if (occ_a !== 2'd0 || cnt_a !== 2'd0) begin
            errors++;
            $display("FAIL flush_fire_cnt got occ=%0d cnt=%0d exp occ=0 cnt=0", occ_a, cnt_a);
        end
    endtask

    task automatic test_flush_full();
        a_out.ready = 1'b0;
        a_in.valid = 1'b1;
        a_in.data = 64'd7;
        tick();
        a_in.data = 64'd8;
        tick();
        a_in.data = 64'd9;
        flush_a = 1'b1;
        #1;
        checks++;
        if (occ_a !== 2'd2) begin
            errors++;
            $display("FAIL flush_full_pre got occ=%0d exp occ=2", occ_a);
        end
        tick();
        flush_a = 1'b0;
        a_in.valid = 1'b0;
        #1;
        checks++;
        if (occ_a !== 2'd0 || a_out.data !== 64'h0 || a_out.valid !== 1'b0 || cnt_a !== 2'd2) begin
            errors++;
            $display("FAIL flush_full got occ=%0d v=%b d=%h cnt=%0d exp occ=0 v=0 d=0 cnt=2",
                     occ_a, a_out.valid, a_out.data, cnt_a);
        end
        a_out.ready = 1'b1;
        tick();
        tick();
        checks++;
        if (a_out.valid !== 1'b0 || occ_a !== 2'd0) begin
            errors++;
            $display("FAIL flush_beat9_gone got v=%b d=%h exp v=0", a_out.valid, a_out.data);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 2; i++) begin
            a_out.ready = 1'b0;
            a_in.valid = 1'b1;
            a_in.data = 64'(32 + i);
            tick();
            tick();
            a_in.valid = 1'b0;
            flush_a = 1'b1;
            #1;
            checks++;
            if (occ_a !== 2'd2) begin
                errors++;
                $display("FAIL sat_pre i=%0d got occ=%0d exp occ=2", i, occ_a);
            end
            tick();
            flush_a = 1'b0;
            #1;
            checks++;
            if (cnt_a !== 2'd3 || occ_a !== 2'd0) begin
                errors++;
                $display("FAIL sat_cnt i=%0d got cnt=%0d occ=%0d exp cnt=3 occ=0", i, cnt_a, occ_a);
            end
        end
    endtask

    task automatic test_noskid();
        logic [DW-1:0] exp_d;
        b_out.ready = 1'b1;
        b_in.valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b_in.data = 64'(8'hA0 + k);
            exp_d = 64'(8'hA0 + k);
            #1;
            checks++;
            if (b_in.ready !== 1'b1) begin
                errors++;
                $display("FAIL noskid_rdy k=%0d got=%b exp=1", k, b_in.ready);
            end
            tick();
            checks++;
            if (b_out.valid !== 1'b1 || b_out.data !== exp_d || occ_b !== 2'd1) begin
                errors++;
                $display("FAIL noskid_stream k=%0d got v=%b d=%h occ=%0d exp v=1 d=%h occ=1",
                         k, b_out.valid, b_out.data, occ_b, exp_d);
            end
        end
        b_out.ready = 1'b0;
        b_in.data = 64'hB0;
        #1;
        checks++;
        if (b_in.ready !== 1'b0) begin
            errors++;
            $display("FAIL noskid_stall_rdy got=%b exp=0", b_in.ready);
        end
        tick();
        checks++;
        if (b_out.data !== 64'hA4 || occ_b !== 2'd1) begin
            errors++;
            $display("FAIL noskid_hold got d=%h occ=%0d exp d=a4 occ=1", b_out.data, occ_b);
        end
        b_out.ready = 1'b1;
        #1;
        checks++;
        if (b_in.ready !== 1'b1) begin
            errors++;
            $display("FAIL noskid_resume_rdy got=%b exp=1", b_in.ready);
        end
        tick();
        b_in.valid = 1'b0;
        #1;
        checks++;
        if (b_out.data !== 64'hB0 || b_out.valid !== 1'b1) begin
            errors++;
            $display("FAIL noskid_accept got v=%b d=%h exp v=1 d=b0", b_out.valid, b_out.data);
        end
        tick();
        checks++;
        if (b_out.valid !== 1'b0 || occ_b !== 2'd0) begin
            errors++;
            $display("FAIL noskid_empty got v=%b occ=%0d exp v=0 occ=0", b_out.valid, occ_b);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_flush_out_fire();
        test_flush_full();
        test_saturation();
        test_noskid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised elastic pipeline stage register with a valid/ready handshake on both sides, an optional skid entry, flush-to-NOP and a saturating flush-drop counter. It is the common building block for every inter-stage register in the 5-stage pipeline: IF/ID, ID/EX, EX/MEM and MEM/WB. Each instance carries an arbitrary payload, for example instruction plus PC+4 in IF/ID. The producer and consumer stages stall each other through the handshake instead of through a global stall wire.

## Interface
- DATA_W, 64, payload width (IF/ID: {instr, PCplus4}).
- SKID, 1: 1 gives 2 entries with registered in_ready; 0 gives 1 entry with in_ready combinational from out_ready.
- NOP_DATA, all-zero (DATA_W bits), value driven on out_data whenever out_valid=0.
- CNT_W, 16, width of flush_drop_cnt.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and the incoming beat this cycle.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  producer payload.
- out_valid  out  1  stage holds a beat for the consumer.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  oldest held payload, or NOP_DATA.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- flush_drop_cnt  out  CNT_W  saturating count of valid entries discarded by flush.

## Operation
- Handshake definitions:
  - in_fire = in_valid & in_ready & !flush.
  - out_fire = out_valid & out_ready.
- Entries and ordering:
  - Entries are main (head) and skid. Order is FIFO; no beat is duplicated or reordered.
- States track occupancy: EMPTY(0), ONE(1), TWO(2, SKID=1 only).
- State transitions:
  - EMPTY: in_fire loads main and goes to ONE.
  - ONE:
    - in_fire & out_fire: main is replaced, stay in ONE.
    - in_fire only: SKID=1 loads skid and goes to TWO. SKID=0 cannot occur, because in_ready=0.
    - out_fire only: go to EMPTY.
  - TWO: out_fire moves skid to main and goes to ONE. in_ready=0, so there is no in_fire.
- in_ready:
  - SKID=1: in_ready = (occupancy != 2), a pure function of registered state.
  - SKID=0: in_ready = (occupancy == 0) | out_ready.
- Outputs:
  - out_valid = (occupancy != 0).
  - out_data = main when valid, else NOP_DATA.
  - out_data and out_valid are stable while out_valid & !out_ready.
- Producer rule: once in_valid is asserted, in_data is held until in_fire or flush.
- Flush:
  - On the next edge, occupancy becomes 0 and out_data becomes NOP_DATA.
  - The beat presented on in_data in the flush cycle is dropped and not counted.
  - out_fire in the flush cycle is a legal delivery, not a drop.
  - flush_drop_cnt += occupancy − out_fire, saturating at 2^CNT_W−1 with no wrap.
- Simultaneous flush and reset: reset wins.
- Reset (synchronous, on the edge where reset=1):
  - occupancy=0, out_valid=0, out_data=NOP_DATA, flush_drop_cnt=0.
  - in_ready is forced to 0 while reset=1.
  - Reset mid-operation discards all entries without counting them.

## Timing
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N, so 1 cycle.
- Throughput:
  - 1 beat/cycle when out_ready is held high, for both SKID values.
  - SKID=1 sustains 1 beat/cycle across single-cycle out_ready drops without a bubble.
- First beat after reset: in_ready=1 in the first cycle with reset=0.
- Combinational paths:
  - SKID=1: none from out_ready to in_ready.
  - SKID=0: one path from out_ready to in_ready.

## Structure
- Package pipe_pkg holds:
  - the NOP encodings (NOP_INSTR = 32'h0000_0000);
  - the occupancy state encoding (EMPTY/ONE/TWO);
  - the stage payload widths (IF_ID_W=64, etc.).
- No sub-module is needed. Implement the saturating counter inline, in a separate always block.
- Use a generate branch on SKID, so that the skid register is absent when SKID=0.

## Test plan
- **Reset and latency:**
  - Stimulus: hold reset for 2 cycles, then in_valid=1 with in_data=64'h00000013_00000004, out_ready=1.
  - Required: in_ready=0 during reset; out_valid=1 with that data exactly 1 cycle after in_fire; out_data=0 before that.
- **Backpressure (SKID=1):**
  - Stimulus: stream beats 1,2,3,4 with out_ready=0 for 3 cycles.
  - Required: occupancy reaches 2; in_ready=0; beat 3 held at input.
  - Stimulus: then out_ready=1.
  - Required: output 1,2,3,4 in order with no gaps or duplicates.
- **Flush while full:**
  - Stimulus: occupancy=2 with out_ready=0; pulse flush with in_valid=1 and data 9.
  - Required: next cycle occupancy=0, out_data=NOP_DATA, flush_drop_cnt=2, beat 9 never appears.
- **Flush with out_fire:**
  - Stimulus: occupancy=1, out_ready=1, flush=1.
  - Required: the beat is delivered; flush_drop_cnt is unchanged.
- **Counter saturation (CNT_W=2):**
  - Stimulus: 3 flushes each dropping 2 entries.
  - Required: count goes 2 → 3 → 3.
- **SKID=0 mode:**
  - Stimulus: continuous stream with out_ready=1.
  - Required: 1 beat/cycle and occupancy never exceeds 1.
  - Stimulus: drop out_ready for 1 cycle.
  - Required: in_ready=0 that cycle; input beat held until accepted.
